shift_arb: RTL and testbench



---
 rtl/shift_arb_pkg.sv | 16 +
 rtl/shift_arb_if.sv | 46 ++++
 rtl/shift_arb_rr_arb2.sv | 30 +++
 rtl/shift_arb.sv | 123 ++++++++++++
 tb/tb_shift_arb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_arb_pkg.sv
// Shared constants for the shift_arb slice: opcodes, requester IDs, default width.
package shift_arb_pkg;

  localparam int BITS_DEFAULT = 16;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SLA = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/shift_arb_if.sv
// Request/response bundle between two shift clients, the arbiter and the consumer.
interface shift_arb_if
  import shift_arb_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
);
  logic            req0_valid;
  logic            req0_ready;
  logic [BITS-1:0] req0_a;
  logic [BITS-1:0] req0_b;
  logic [2:0]      req0_op;

  logic            req1_valid;
  logic            req1_ready;
  logic [BITS-1:0] req1_a;
  logic [BITS-1:0] req1_b;
  logic [2:0]      req1_op;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_result;
  logic            rsp_id;
  logic            rsp_err;

  logic [15:0]     grant_cnt0;
  logic [15:0]     grant_cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_id, rsp_err,
    input  grant_cnt0, grant_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_id, rsp_err,
    output grant_cnt0, grant_cnt1
  );

endinterface

// File: rtl/shift_arb_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; grants only when the slot is free.
module rr_arb2
  import shift_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic free,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  // Pointer resets to REQ1 so requester 0 wins the first tie.
  req_id_e last_q, last_d;

  always_comb begin
    gnt0   = free & valid0 & (~valid1 | (last_q == REQ1));
    gnt1   = free & valid1 & (~valid0 | (last_q == REQ0));
    last_d = last_q;
    if (gnt0)      last_d = REQ0;
    else if (gnt1) last_d = REQ1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/shift_arb.sv
// Two-requester shift arbiter with one registered response stage.
// Optional grant counters are enabled with `define SHIFT_ARB_STATS_EN.
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  shift_arb_if.slave  bus
);

  function automatic logic [BITS:0] shift_calc(input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b,
                                               input logic [2:0]      op);
    logic signed [BITS-1:0] sa;
    logic [BITS:0]          r;
    sa = $signed(a);
    case (op)
      OP_SLL, OP_SLA: r = {1'b0, a << b};
      OP_SRL:         r = {1'b0, a >> b};
      // >>> on a signed operand sign-fills, including shifts of BITS or more.
      OP_SRA:         r = {1'b0, sa >>> b};
      default:        r = {1'b1, {BITS{1'b0}}};
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic            free, gnt0, gnt1, fire;
  logic [BITS-1:0] sel_a, sel_b;
  logic [2:0]      sel_op;
  logic [BITS:0]   calc;

  logic            rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;

  // No accept is allowed in a reset cycle.
  assign free = (~rsp_valid_q | bus.rsp_ready) & ~rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .free   (free),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign fire           = gnt0 | gnt1;

  always_comb begin
    sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
    sel_op = gnt1 ? bus.req1_op : bus.req0_op;
    calc   = shift_calc(sel_a, sel_b, sel_op);

    rsp_valid_d  = rsp_valid_q & ~bus.rsp_ready;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    if (fire) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = calc[BITS-1:0];
      rsp_id_d     = gnt1 ? REQ1 : REQ0;
      rsp_err_d    = calc[BITS];
    end
  end

  // ---- response stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = gnt0 ? sat_inc(cnt0_q) : cnt0_q;
    cnt1_d = gnt1 ? sat_inc(cnt1_q) : cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
`else
  assign bus.grant_cnt0 = 16'd0;
  assign bus.grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_shift_arb.sv
// Randomized bench for shift_arb against a behavioural arbiter/shift model.
module tb_shift_arb;

  localparam int BITS = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shift_arb_if #(.BITS(BITS)) bus ();

  shift_arb #(.BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // model state
  bit          m_valid;
  logic [15:0] m_res;
  bit          m_id;
  bit          m_err;
  int          m_last;
  int          m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-by-bit shift reference.
  function automatic logic [16:0] ref_shift(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    logic [15:0] r;
    int sh, src;
    if (op[2]) return {1'b1, 16'h0000};
    sh = (b >= 16) ? 16 : int'(b);
    for (int i = 0; i < 16; i++) begin
      case (op[1:0])
        2'b00, 2'b10: begin src = i - sh; r[i] = (src >= 0) ? a[src] : 1'b0; end
        2'b01:        begin src = i + sh; r[i] = (src < 16) ? a[src] : 1'b0; end
        default:      begin src = i + sh; r[i] = (src < 16) ? a[src] : a[15]; end
      endcase
    end
    return {1'b0, r};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_id = 0; m_err = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic tick();
    bit free, e0, e1;
    logic [16:0] r;
    @(negedge clk);
    free = (!m_valid || bus.rsp_ready) && !rst;
    e0 = free && bus.req0_valid && (!bus.req1_valid || m_last == 1);
    e1 = free && bus.req1_valid && (!bus.req0_valid || m_last == 0);
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("rsp_valid",  bus.rsp_valid,  m_valid);
    chk("rsp_result", bus.rsp_result, m_res);
    chk("rsp_id",     bus.rsp_id,     m_id);
    chk("rsp_err",    bus.rsp_err,    m_err);
`ifdef SHIFT_ARB_STATS_EN
    chk("grant_cnt0", bus.grant_cnt0, m_cnt0);
    chk("grant_cnt1", bus.grant_cnt1, m_cnt1);
`else
    chk("grant_cnt0", bus.grant_cnt0, 0);
    chk("grant_cnt1", bus.grant_cnt1, 0);
`endif
    @(posedge clk);
    if (rst) model_reset();
    else if (e0 || e1) begin
      r = e1 ? ref_shift(bus.req1_a, bus.req1_b, bus.req1_op)
             : ref_shift(bus.req0_a, bus.req0_b, bus.req0_op);
      m_valid = 1; m_res = r[15:0]; m_err = r[16]; m_id = e1; m_last = e1 ? 1 : 0;
      if (e0 && m_cnt0 < 16'hFFFF) m_cnt0++;
      if (e1 && m_cnt1 < 16'hFFFF) m_cnt1++;
    end else if (m_valid && bus.rsp_ready) m_valid = 0;
    #1;
  endtask

  task automatic drive(input bit v0, input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] o0,
                       input bit v1, input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] o1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = o1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    rst = 1;
    bus.rsp_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tick(); tick();
    rst = 0;

    // 1: idle, then one left shift
    tick();
    chk("idle_valid", bus.rsp_valid, 0);
    drive(1, 16'h00F0, 4, 3'b000, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_result", bus.rsp_result, 16'h0F00);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_err", bus.rsp_err, 0);
    tick();

    // 2: both valid for 6 cycles alternate starting with 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'h0001, i, 3'b000, 1, 16'h8000, i, 3'b001);
      tick();
      chk("t2_id", bus.rsp_id, i % 2);
      chk("t2_valid", bus.rsp_valid, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 3: arithmetic and logical right edges
    drive(1, 16'h8000, 3, 3'b011, 0, 0, 0, 0);  tick(); chk("sra3",  bus.rsp_result, 16'hF000);
    drive(1, 16'h8000, 20, 3'b011, 0, 0, 0, 0); tick(); chk("sra20", bus.rsp_result, 16'hFFFF);
    drive(1, 16'h4000, 2, 3'b011, 0, 0, 0, 0);  tick(); chk("sra_pos", bus.rsp_result, 16'h1000);
    drive(1, 16'hFFFF, 16, 3'b001, 0, 0, 0, 0); tick(); chk("srl16", bus.rsp_result, 16'h0000);
    drive(1, 16'hABCD, 0, 3'b010, 0, 0, 0, 0);  tick(); chk("sla0",  bus.rsp_result, 16'hABCD);

    // 4: backpressure with both requesters valid
    do_reset();
    drive(1, 16'h0003, 1, 3'b000, 1, 16'h0F00, 4, 3'b001);
    tick();
    bus.rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_result", bus.rsp_result, 16'h0006);
      chk("bp_id", bus.rsp_id, 0);
    end
    bus.rsp_ready = 1;
    tick();
    chk("bp_next_id", bus.rsp_id, 1);
    chk("bp_next_result", bus.rsp_result, 16'h00F0);

    // 5: illegal opcode, then reset with a held response
    drive(1, 16'h1234, 1, 3'b101, 0, 0, 0, 0);
    tick();
    chk("ill_result", bus.rsp_result, 0);
    chk("ill_err", bus.rsp_err, 1);
    bus.rsp_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1; tick(); rst = 0;
    chk("rst_valid", bus.rsp_valid, 0);
    bus.rsp_ready = 1;
    drive(1, 16'h0001, 1, 3'b000, 1, 16'h0001, 1, 3'b000);
    tick();
    chk("rst_ptr_id", bus.rsp_id, 0);

    // 6: grant counts
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1, i, 1, 3'b000, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 1, i, 1, 3'b001);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
`ifdef SHIFT_ARB_STATS_EN
    chk("cnt0_3", bus.grant_cnt0, 3);
    chk("cnt1_2", bus.grant_cnt1, 2);
`else
    chk("cnt0_off", bus.grant_cnt0, 0);
    chk("cnt1_off", bus.grant_cnt1, 0);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] b0, b1;
      b0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      b1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      drive($urandom_range(0, 1), 16'($urandom), b0, 3'($urandom),
            $urandom_range(0, 1), 16'($urandom), b1, 3'($urandom));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
